montprowrap_drv: RTL and testbench

//  Initiator-side driver for the montprowrap start/done Montgomery-product handshake.

---
 rtl/montprowrap_drv.sv | 145 ++++++++++++++
 tb/tb_montprowrap_drv.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/montprowrap_drv.sv
// montprowrap_drv: initiator-side driver for the montprowrap start/done handshake.
//
// It accepts one operand pair at a time on a valid/ready input and launches it on the
// multiplier with a single-cycle start pulse. The operands are held stable until the
// product is returned on a valid/ready output. If the multiplier does not answer
// within TMO_CYC cycles, the driver returns an error result instead.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a/in_b are the operands
//   mm_a/mm_b/mm_start   operands and start pulse to the multiplier
//   mm_r/mm_done         product and completion strobe from the multiplier
//   out_valid/out_ready  result handshake; out_r is the product, out_err flags a timeout
//   op_cnt               completed ops (products and timeouts), wraps at 8 bits
//
// Every output comes straight from a flop.
module montprowrap_drv #(
  parameter int unsigned WID     = 256,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WID-1:0] in_a,
  input  logic [WID-1:0] in_b,
  output logic [WID-1:0] mm_a,
  output logic [WID-1:0] mm_b,
  output logic           mm_start,
  input  logic [WID-1:0] mm_r,
  input  logic           mm_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] out_r,
  output logic           out_err,
  output logic [7:0]     op_cnt
);

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e           state_q, state_d;
  logic [WID-1:0]   mm_a_q, mm_a_d;
  logic [WID-1:0]   mm_b_q, mm_b_d;
  logic             mm_start_q, mm_start_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WID-1:0]   out_r_q, out_r_d;
  logic             out_err_q, out_err_d;
  logic [7:0]       op_cnt_q, op_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    state_d     = state_q;
    mm_a_d      = mm_a_q;
    mm_b_d      = mm_b_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_err_d   = out_err_q;
    op_cnt_d    = op_cnt_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mm_a_d  = in_a;
          mm_b_d  = in_b;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // A done seen here belongs to nothing we launched; it is ignored.
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done wins over a timeout that expires in the same cycle.
        if (mm_done) begin
          out_r_d     = mm_r;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          op_cnt_d    = op_cnt_q + 8'd1;
          state_d     = StHold;
        end else if (tmo_q == TmoLast) begin
          out_r_d     = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          op_cnt_d    = op_cnt_q + 8'd1;
          state_d     = StHold;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Decode these from the next state so that they stay registered outputs.
    mm_start_d = (state_d == StIssue);
    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      mm_start_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_err_q   <= 1'b0;
      op_cnt_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mm_a_q      <= mm_a_d;
      mm_b_q      <= mm_b_d;
      mm_start_q  <= mm_start_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_err_q   <= out_err_d;
      op_cnt_q    <= op_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign mm_start  = mm_start_q;
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_err   = out_err_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_montprowrap_drv.sv
// Directed bench for montprowrap_drv (WID=4, TMO_CYC=8) with a stub multiplier.
// The stub raises done stub_dly cycles after the start pulse and returns r=(a*b)%16.
// Setting stub_dly to 0 makes the stub never answer.
module tb_montprowrap_drv;

  localparam int unsigned Wid = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [Wid-1:0] in_a, in_b;
  logic [Wid-1:0] mm_a, mm_b;
  logic           mm_start;
  logic [Wid-1:0] mm_r;
  logic           mm_done;
  logic           out_valid;
  logic           out_ready;
  logic [Wid-1:0] out_r;
  logic           out_err;
  logic [7:0]     op_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Stub multiplier
  int   stub_dly = 3;
  int   stub_cd  = 0;
  logic stub_pend = 1'b0;
  logic stub_done = 1'b0;
  logic extra_done;
  int   start_cnt = 0;

  always #5 clk = ~clk;

  montprowrap_drv #(
    .WID    (Wid),
    .TMO_W  (16),
    .TMO_CYC(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_start (mm_start),
    .mm_r     (mm_r),
    .mm_done  (mm_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .out_err  (out_err),
    .op_cnt   (op_cnt)
  );

  assign mm_r    = Wid'(mm_a * mm_b);
  assign mm_done = stub_done | extra_done;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (mm_start) begin
      start_cnt <= start_cnt + 1;
      if (stub_dly != 0) begin
        stub_pend <= 1'b1;
        stub_cd   <= stub_dly - 1;
      end
    end else if (stub_pend) begin
      if (stub_cd == 1) begin
        stub_done <= 1'b1;
        stub_pend <= 1'b0;
      end else begin
        stub_cd <= stub_cd - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until out_valid is seen (bounded); returns the number of ticks taken.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  // Presents one pair, returns once the accepting edge has passed.
  task automatic issue(input logic [Wid-1:0] a, input logic [Wid-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int s0;
    logic [Wid-1:0] exp_r [3];
    logic [Wid-1:0] pa [3];
    logic [Wid-1:0] pb [3];

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    extra_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mm_start", 32'(mm_start), 32'd0);
    chk("rst_op_cnt", 32'(op_cnt), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_mm_a", 32'(mm_a), 32'd0);

    // T1: single op 10*5 -> 50 mod 16 = 2
    s0 = start_cnt;
    issue(4'd10, 4'd5);
    chk("t1_start_hi", 32'(mm_start), 32'd1);
    chk("t1_mm_a", 32'(mm_a), 32'd10);
    chk("t1_mm_b", 32'(mm_b), 32'd5);
    chk("t1_busy", 32'(in_ready), 32'd0);
    tick();
    chk("t1_start_lo", 32'(mm_start), 32'd0);
    wait_valid("t1", lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_out_r", 32'(out_r), 32'd2);
    chk("t1_out_err", 32'(out_err), 32'd0);
    chk("t1_op_cnt", 32'(op_cnt), 32'd1);
    chk("t1_mm_a_held", 32'(mm_a), 32'd10);
    chk("t1_mm_b_held", 32'(mm_b), 32'd5);
    chk("t1_one_start", 32'(start_cnt - s0), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t1_drop_valid", 32'(out_valid), 32'd0);
    chk("t1_idle_ready", 32'(in_ready), 32'd1);

    // T2: streamed pairs with out_ready held high
    pa[0] = 4'd7;  pb[0] = 4'd5;  exp_r[0] = 4'd3;
    pa[1] = 4'd15; pb[1] = 4'd15; exp_r[1] = 4'd1;
    pa[2] = 4'd13; pb[2] = 4'd14; exp_r[2] = 4'd6;
    for (int i = 0; i < 3; i++) begin
      wait_ready($sformatf("t2_%0d", i));
      issue(pa[i], pb[i]);
      wait_valid($sformatf("t2_%0d", i), lat);
      chk($sformatf("t2_out_r_%0d", i), 32'(out_r), 32'(exp_r[i]));
      chk($sformatf("t2_err_%0d", i), 32'(out_err), 32'd0);
    end
    chk("t2_op_cnt", 32'(op_cnt), 32'd4);
    tick();
    chk("t2_idle", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // T3: multiplier never answers -> timeout
    stub_dly = 0;
    issue(4'd3, 4'd3);
    chk("t3_start_hi", 32'(mm_start), 32'd1);
    wait_valid("t3", lat);
    chk("t3_latency", 32'(lat), 32'd9);
    chk("t3_out_err", 32'(out_err), 32'd1);
    chk("t3_out_r", 32'(out_r), 32'd0);
    chk("t3_op_cnt", 32'(op_cnt), 32'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_drop_valid", 32'(out_valid), 32'd0);

    // T4: consumer stalls; stray done pulses and new pairs are ignored in HOLD
    stub_dly = 3;
    wait_ready("t4");
    issue(4'd6, 4'd7);
    wait_valid("t4", lat);
    chk("t4_out_r", 32'(out_r), 32'd10);
    in_valid = 1'b1;
    in_a     = 4'd1;
    in_b     = 4'd2;
    for (int i = 0; i < 5; i++) begin
      extra_done = (i % 2 == 0);
      tick();
      chk($sformatf("t4_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("t4_out_r_%0d", i), 32'(out_r), 32'd10);
      chk($sformatf("t4_busy_%0d", i), 32'(in_ready), 32'd0);
    end
    extra_done = 1'b0;
    chk("t4_mm_a", 32'(mm_a), 32'd6);
    chk("t4_op_cnt", 32'(op_cnt), 32'd6);
    chk("t4_err", 32'(out_err), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("t4_no_buffer", 32'(mm_start), 32'd0);
    chk("t4_idle", 32'(in_ready), 32'd1);

    // T5: reset in WAIT; the late done must not produce a result
    issue(4'd2, 4'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_start_lo", 32'(mm_start), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t5_no_valid_%0d", i), 32'(out_valid), 32'd0);
    end
    chk("t5_op_cnt", 32'(op_cnt), 32'd0);
    chk("t5_ready_end", 32'(in_ready), 32'd1);

    // T6: done lands on the timeout cycle -> product wins; 9*9 = 81 mod 16 = 1
    stub_dly = 8;
    issue(4'd9, 4'd9);
    wait_valid("t6", lat);
    chk("t6_latency", 32'(lat), 32'd9);
    chk("t6_out_err", 32'(out_err), 32'd0);
    chk("t6_out_r", 32'(out_r), 32'd1);
    chk("t6_op_cnt", 32'(op_cnt), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
